br_redirect_ctl: RTL and testbench
==================================

Name: br_redirect_ctl

Overview:
- Sits directly downstream of the integer branch units in EX.
- Collects per-port branch-mispredict packets in EX0 and selects the oldest by ROB age.
- Registers the selection, broadcasts a one-cycle pipeline flush, drives a valid/ready redirect to fetch, then holds until recovery completes.
- During a pending redirect or recovery, an older mispredict supersedes the pending one; younger or equal ones are dropped.

Parameters:
- NUM_BR, 2: number of branch-unit mispredict ports.
- CNT_W, 16: width of the mispredict event counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- br_mispred_ex0  in  NUM_BR x t_br_mispred_pkt  per-port {valid, target_addr, robid}.
- rob_nuke  in  1  ROB-initiated full flush; discards all pending state.
- fe_redirect_vld  out  1  redirect request to fetch.
- fe_redirect_addr  out  t_paddr  redirect target.
- fe_redirect_rdy  in  1  fetch accepts the redirect when vld&rdy.
- flush_vld  out  1  one-cycle flush pulse to the pipeline.
- flush_robid  out  t_rob_id  flush everything strictly younger than this robid.
- recover_done  in  1  rename/ROB recovery complete.
- busy  out  1  state != IDLE.
- mispred_cnt  out  CNT_W  count of captured mispredicts, wraps.

Behaviour:
- Age rule: t_rob_id = {wrap, idx}. a is older than b iff (a.wrap != b.wrap) XOR (a.idx < b.idx). Equal robids are not older.
- Port select (combinational):
  - Oldest valid port wins.
  - Ties go to the lowest port index (illegal in practice, but deterministic).
  - Result is cand_vld, cand_addr, cand_robid.
- Capture condition:
  - cap = cand_vld & ~rob_nuke & (state==IDLE | cand older than pend_robid).
  - On cap: pend_addr <= cand_addr, pend_robid <= cand_robid, state <= REDIRECT, mispred_cnt++.
- States:
  - IDLE: cap -> REDIRECT.
  - REDIRECT: fe_redirect_vld=1, fe_redirect_addr=pend_addr.
    - cap -> REDIRECT (replace pending).
    - Else vld&rdy -> RECOVER.
  - RECOVER: wait for recovery.
    - cap -> REDIRECT, with priority over recover_done.
    - Else recover_done -> IDLE.
- Simultaneous accept and cap in REDIRECT: the old redirect is consumed, the new one is captured, state stays REDIRECT, and fetch sees a second redirect the next cycle.
- Address stability: fe_redirect_addr stays constant while vld&~rdy, except on a cap replacement. Fetch samples only on vld&rdy.
- Latency: mispredict in EX0 cycle N -> flush_vld and fe_redirect_vld high in cycle N+1, both driven from flops. No combinational path from br_mispred_ex0 to any output.
- flush_vld: registered; high exactly one cycle after each cap. flush_robid = pend_robid.
- rob_nuke:
  - Highest priority; synchronous clear to IDLE.
  - Same-cycle mispredicts are ignored.
  - flush_vld is not pulsed and mispred_cnt is unchanged.
- recover_done in IDLE or REDIRECT: ignored.
- Reset (async, reset==0):
  - state=IDLE; fe_redirect_vld=0, fe_redirect_addr=0, flush_vld=0, flush_robid=0, busy=0, mispred_cnt=0.
  - Deassertion mid-operation restarts from IDLE; any in-flight redirect is lost.
- mispred_cnt wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package (common): t_rob_id with wrap bit, function rob_older(a,b), enum t_redir_state {IDLE, REDIRECT, RECOVER}.
- Reuse existing t_br_mispred_pkt and t_paddr.
- One sub-module: br_oldest_sel, a parameterised NUM_BR-way oldest-select tree producing cand_vld/addr/robid.

Test Plan:
- Single mispredict: port0 valid, robid 0x05, target 0x1000; rdy=1; recover_done pulsed 3 cycles later -> next cycle flush_vld=1 with flush_robid=0x05 and fe_redirect_vld=1 with addr 0x1000; then RECOVER, then IDLE; mispred_cnt=1.
- Oldest select with wrap: port0 robid {1,0x02}, port1 robid {0,0x1E}, both valid -> port1 captured; flush_robid={0,0x1E}.
- Backpressure with supersede: rdy=0, pending robid 0x08 addr 0x2000; port0 sends robid 0x04 addr 0x3000 -> addr becomes 0x3000, second flush_vld pulse; a later robid 0x09 is dropped with no pulse and no count.
- Races:
  - Accept and older mispredict in the same cycle -> state stays REDIRECT, second redirect with the new addr next cycle.
  - recover_done and older mispredict in the same cycle -> REDIRECT, not IDLE.
- rob_nuke during REDIRECT with a simultaneous port0 mispredict -> next cycle IDLE, fe_redirect_vld=0, no flush_vld, count unchanged.
- Async reset mid-REDIRECT: reset=0 between clock edges -> outputs go to 0 immediately; after release, first mispredict behaves as in the single-mispredict case; counter wraps from 0xFFFF to 0 on the next capture.

Source files
------------

// File: rtl/br_redirect_ctl_pkg.sv
// Shared types for branch-redirect control: ROB ids with wrap bit, mispredict packets,
// redirect FSM states and the ROB age comparison.
package br_redirect_ctl_pkg;

    localparam int PADDR_W   = 32;
    localparam int ROB_IDX_W = 6;

    typedef logic [PADDR_W-1:0] t_paddr;

    typedef struct packed {
        logic                 wrap;
        logic [ROB_IDX_W-1:0] idx;
    } t_rob_id;

    typedef struct packed {
        logic    valid;
        t_paddr  target_addr;
        t_rob_id robid;
    } t_br_mispred_pkt;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        RECOVER  = 2'd2
    } t_redir_state;

    // a is older than b when it sits earlier in the ROB; equal ids are not older.
    function automatic logic rob_older(input t_rob_id a, input t_rob_id b);
        return (a.wrap != b.wrap) ^ (a.idx < b.idx);
    endfunction

endpackage

// File: rtl/br_oldest_sel.sv
// NUM_BR-way oldest-mispredict select; ties keep the lowest port index.
module br_oldest_sel
    import br_redirect_ctl_pkg::*;
#(
    parameter int NUM_BR = 2
) (
    input  t_br_mispred_pkt br_mispred [NUM_BR],
    output logic            cand_vld,
    output t_paddr          cand_addr,
    output t_rob_id         cand_robid
);

    always_comb begin
        logic    sel_vld;
        t_paddr  sel_addr;
        t_rob_id sel_robid;
        sel_vld   = 1'b0;
        sel_addr  = '0;
        sel_robid = '0;
        // Strictly-older replacement so an equal-age later port never displaces an earlier one.
        for (int i = 0; i < NUM_BR; i++) begin
            if (br_mispred[i].valid && (!sel_vld || rob_older(br_mispred[i].robid, sel_robid))) begin
                sel_vld   = 1'b1;
                sel_addr  = br_mispred[i].target_addr;
                sel_robid = br_mispred[i].robid;
            end
        end
        cand_vld   = sel_vld;
        cand_addr  = sel_addr;
        cand_robid = sel_robid;
    end

endmodule

// File: rtl/br_redirect_ctl.sv
// Branch-mispredict redirect controller: picks the oldest EX0 mispredict, pulses a flush,
// hands the redirect to fetch and holds until recovery completes.
module br_redirect_ctl
    import br_redirect_ctl_pkg::*;
#(
    parameter int NUM_BR = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  t_br_mispred_pkt  br_mispred_ex0 [NUM_BR],
    input  logic             rob_nuke,
    output logic             fe_redirect_vld,
    output t_paddr           fe_redirect_addr,
    input  logic             fe_redirect_rdy,
    output logic             flush_vld,
    output t_rob_id          flush_robid,
    input  logic             recover_done,
    output logic             busy,
    output logic [CNT_W-1:0] mispred_cnt
);

    t_redir_state state, state_nxt;
    logic         cand_vld_p0;
    t_paddr       cand_addr_p0;
    t_rob_id      cand_robid_p0;
    t_paddr       pend_addr;
    t_rob_id      pend_robid;
    logic         cap;

    br_oldest_sel #(.NUM_BR(NUM_BR)) u_oldest_sel (
        .br_mispred (br_mispred_ex0),
        .cand_vld   (cand_vld_p0),
        .cand_addr  (cand_addr_p0),
        .cand_robid (cand_robid_p0)
    );

    // pend_robid is only meaningful while busy, hence the IDLE bypass.
    assign cap = cand_vld_p0 && !rob_nuke &&
                 ((state == IDLE) || rob_older(cand_robid_p0, pend_robid));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (rob_nuke) begin
            state_nxt = IDLE;
        end else if (cap) begin
            state_nxt = REDIRECT;
        end else begin
            case (state)
                REDIRECT: if (fe_redirect_rdy) state_nxt = RECOVER;
                RECOVER:  if (recover_done)    state_nxt = IDLE;
                default:                       state_nxt = state;
            endcase
        end
    end

    always_comb begin
        fe_redirect_vld  = (state == REDIRECT);
        fe_redirect_addr = (state == REDIRECT) ? pend_addr : '0;
        busy             = (state != IDLE);
        flush_robid      = pend_robid;
    end

    // ---- stage p1: captured redirect, flush pulse and event count ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_addr   <= '0;
            pend_robid  <= '0;
            flush_vld   <= 1'b0;
            mispred_cnt <= '0;
        end else begin
            flush_vld <= cap;
            if (cap) begin
                pend_addr   <= cand_addr_p0;
                pend_robid  <= cand_robid_p0;
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_br_redirect_ctl.sv
// Self-checking bench for br_redirect_ctl: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_br_redirect_ctl;
    import br_redirect_ctl_pkg::*;

    localparam int NUM_BR = 2;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             reset;
    t_br_mispred_pkt  mp [NUM_BR];
    logic             rob_nuke;
    logic             fe_redirect_vld;
    t_paddr           fe_redirect_addr;
    logic             fe_redirect_rdy;
    logic             flush_vld;
    t_rob_id          flush_robid;
    logic             recover_done;
    logic             busy;
    logic [CNT_W-1:0] mispred_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: an outstanding redirect, whether fetch has taken it yet, and its payload.
    logic             m_pend, m_acc, m_flush;
    logic [31:0]      m_addr;
    logic [6:0]       m_robid;
    logic [CNT_W-1:0] m_cnt;

    always #5 clk = ~clk;

    br_redirect_ctl #(.NUM_BR(NUM_BR), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .br_mispred_ex0   (mp),
        .rob_nuke         (rob_nuke),
        .fe_redirect_vld  (fe_redirect_vld),
        .fe_redirect_addr (fe_redirect_addr),
        .fe_redirect_rdy  (fe_redirect_rdy),
        .flush_vld        (flush_vld),
        .flush_robid      (flush_robid),
        .recover_done     (recover_done),
        .busy             (busy),
        .mispred_cnt      (mispred_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Age as modular distance: a is older when b lies 1..half-ring ahead of a.
    function automatic logic m_older(input logic [6:0] a, input logic [6:0] b);
        int d;
        d = (int'(b) - int'(a)) & 127;
        return (d >= 1) && (d <= 64);
    endfunction

    task automatic model_reset();
        m_pend = 0; m_acc = 0; m_flush = 0; m_addr = '0; m_robid = '0; m_cnt = '0;
    endtask

    task automatic model_step();
        logic        found;
        logic [31:0] b_addr;
        logic [6:0]  b_robid;
        found = 0; b_addr = '0; b_robid = '0;
        for (int i = 0; i < NUM_BR; i++)
            if (mp[i].valid && (!found || m_older(mp[i].robid, b_robid))) begin
                found = 1; b_addr = mp[i].target_addr; b_robid = mp[i].robid;
            end
        m_flush = 0;
        if (rob_nuke) begin
            m_pend = 0; m_acc = 0;
        end else if (found && (!m_pend || m_older(b_robid, m_robid))) begin
            m_pend = 1; m_acc = 0; m_flush = 1;
            m_addr = b_addr; m_robid = b_robid; m_cnt = m_cnt + 1'b1;
        end else if (m_pend && !m_acc && fe_redirect_rdy) begin
            m_acc = 1;
        end else if (m_pend && m_acc && recover_done) begin
            m_pend = 0;
        end
    endtask

    task automatic check_outputs();
        chk("redir_vld", fe_redirect_vld, m_pend && !m_acc);
        if (m_pend && !m_acc) chk("redir_addr", fe_redirect_addr, m_addr);
        chk("flush_vld", flush_vld, m_flush);
        if (m_flush) chk("flush_robid", flush_robid, m_robid);
        chk("busy", busy, m_pend);
        chk("mispred_cnt", mispred_cnt, m_cnt);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic clear_in();
        for (int i = 0; i < NUM_BR; i++) begin
            mp[i].valid = 0; mp[i].target_addr = '0; mp[i].robid = '0;
        end
        rob_nuke = 0; recover_done = 0;
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic [6:0] r);
        mp[p].valid = 1; mp[p].target_addr = a; mp[p].robid = r;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"},   fe_redirect_vld, 0);
        chk({tag, "_addr"},  fe_redirect_addr, 0);
        chk({tag, "_flush"}, flush_vld, 0);
        chk({tag, "_robid"}, flush_robid, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_cnt"},   mispred_cnt, 0);
    endtask

    // Single mispredict from port0 carried through redirect, recover and back to idle.
    task automatic single_mispredict(input string tag);
        fe_redirect_rdy = 1;
        set_port(0, 32'h1000, 7'h05);
        cycle();
        chk({tag, "_flush"}, flush_vld, 1);
        chk({tag, "_robid"}, flush_robid, 7'h05);
        chk({tag, "_addr"},  fe_redirect_addr, 32'h1000);
        clear_in();
        cycle();
        chk({tag, "_recover"}, busy && !fe_redirect_vld, 1);
        cycle();
        recover_done = 1;
        cycle();
        recover_done = 0;
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [6:0]  r;
        logic [CNT_W-1:0] c0;
        reset = 0; fe_redirect_rdy = 0;
        clear_in();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1;
        cycle();

        single_mispredict("single");
        chk("single_cnt", mispred_cnt, 1);

        // Wrap-aware select: {0,0x1E} is older than {1,0x02}.
        set_port(0, 32'hA000, 7'h42);
        set_port(1, 32'hB000, 7'h1E);
        cycle();
        chk("wrap_robid", flush_robid, 7'h1E);
        chk("wrap_addr", fe_redirect_addr, 32'hB000);
        clear_in();
        cycle();
        recover_done = 1;
        cycle();
        clear_in();

        // Backpressure with supersede, then a younger one dropped.
        fe_redirect_rdy = 0;
        set_port(0, 32'h2000, 7'h08);
        cycle();
        set_port(0, 32'h3000, 7'h04);
        cycle();
        chk("supersede_addr", fe_redirect_addr, 32'h3000);
        chk("supersede_flush", flush_vld, 1);
        c0 = mispred_cnt;
        set_port(0, 32'h4444, 7'h09);
        cycle();
        chk("drop_flush", flush_vld, 0);
        chk("drop_cnt", mispred_cnt, c0);
        chk("drop_addr", fe_redirect_addr, 32'h3000);
        clear_in();

        // Accept and older mispredict in the same cycle.
        fe_redirect_rdy = 1;
        set_port(1, 32'h5000, 7'h02);
        cycle();
        chk("race_acc_vld", fe_redirect_vld, 1);
        chk("race_acc_addr", fe_redirect_addr, 32'h5000);
        clear_in();
        cycle();

        // recover_done and older mispredict in the same cycle.
        recover_done = 1;
        set_port(0, 32'h6000, 7'h01);
        cycle();
        chk("race_rec_vld", fe_redirect_vld, 1);
        chk("race_rec_busy", busy, 1);
        clear_in();

        // rob_nuke during REDIRECT beats a same-cycle mispredict.
        fe_redirect_rdy = 0;
        c0 = mispred_cnt;
        rob_nuke = 1;
        set_port(0, 32'h7000, 7'h00);
        cycle();
        chk("nuke_vld", fe_redirect_vld, 0);
        chk("nuke_flush", flush_vld, 0);
        chk("nuke_busy", busy, 0);
        chk("nuke_cnt", mispred_cnt, c0);
        clear_in();

        // Asynchronous reset mid-REDIRECT.
        set_port(0, 32'h8000, 7'h10);
        cycle();
        clear_in();
        #3;
        reset = 0;
        #1;
        chk_all_zero("areset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1;
        cycle();
        single_mispredict("post_reset");

        // Counter wrap via back-to-back ever-older captures under backpressure.
        fe_redirect_rdy = 0;
        r = 7'h40;
        while (m_cnt != {CNT_W{1'b1}}) begin
            set_port(0, 32'h9000 + 32'(r), r);
            cycle();
            r = r - 7'd1;
        end
        chk("cnt_max", mispred_cnt, {CNT_W{1'b1}});
        set_port(0, 32'h9000, r);
        cycle();
        chk("cnt_wrap", mispred_cnt, 0);
        clear_in();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NUM_BR; i++) begin
                mp[i].valid       = ($urandom % 4) == 0;
                mp[i].target_addr = $urandom;
                mp[i].robid       = 7'($urandom);
            end
            fe_redirect_rdy = $urandom % 2;
            recover_done    = ($urandom % 3) == 0;
            rob_nuke        = ($urandom % 40) == 0;
            cycle();
        end
        clear_in();
        fe_redirect_rdy = 1;
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
